// File: rtl/debounce_multi.sv
// debounce_multi: N-channel input debouncer with per-channel lock/ack handshake, transition counters and a masked irq.
// Optional macro DEBOUNCE_MULTI_INVERT_EN adds a per-channel invert input applied after synchronisation.
module debounce_multi #(
    parameter int CHANNELS = 8,
    parameter int TIMER_W  = 16,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic [CHANNELS-1:0]       unlock,
`ifdef DEBOUNCE_MULTI_INVERT_EN
    input  logic [CHANNELS-1:0]       invert,
`endif
    input  logic [TIMER_W-1:0]        timeout,
    input  logic [CHANNELS-1:0]       irq_en,
    output logic [CHANNELS-1:0]       sig_out,
    output logic [CHANNELS-1:0]       sig_changed,
    output logic [CHANNELS*CNT_W-1:0] cycles,
    output logic                      irq
);
    typedef enum logic [1:0] {STABLE, BOUNCE1, BOUNCE2} filt_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_t;
    logic [CHANNELS-1:0] s1, sig, d;
    // two-flop synchroniser for the raw asynchronous inputs
    always_ff @(posedge clk) begin
        s1  <= reset ? '0 : sig_in;
        sig <= reset ? '0 : s1;
    end
`ifdef DEBOUNCE_MULTI_INVERT_EN
    assign d = sig ^ invert;
`else
    assign d = sig;
`endif
    // interrupt lags the pending flags by one cycle
    always_ff @(posedge clk)
        irq <= reset ? 1'b0 : |(sig_changed & irq_en);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        filt_t              fs, fs_n;
        lock_t              ls, ls_n;
        logic [TIMER_W-1:0] tmr, tmr_n, tmr_inc;
        logic [CNT_W-1:0]   cnt, cnt_n;
        logic               val, val_n, vc, so, so_n;
        // timer saturates so a maximal timeout can never wrap it back to zero
        assign tmr_inc = (&tmr) ? tmr : tmr + TIMER_W'(1);
        // filter and lock state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                fs  <= STABLE;
                ls  <= UNLOCKED;
                tmr <= '0;
                val <= 1'b0;
                so  <= 1'b0;
                cnt <= '0;
            end else begin
                fs  <= fs_n;
                ls  <= ls_n;
                tmr <= tmr_n;
                val <= val_n;
                so  <= so_n;
                cnt <= cnt_n;
            end
        end
        // bounce filter: value follows d only after it holds for timeout+2 cycles past the first mismatch
        always_comb begin
            fs_n  = fs;
            tmr_n = tmr;
            val_n = val;
            vc    = 1'b0;
            case (fs)
                STABLE: if (d[g] != val) begin
                    fs_n  = BOUNCE1;
                    tmr_n = '0;
                end
                BOUNCE1: if (d[g] != val) begin
                    if (tmr > timeout) begin
                        val_n = d[g];
                        fs_n  = STABLE;
                        vc    = 1'b1;
                    end else tmr_n = tmr_inc;
                end else begin
                    fs_n  = BOUNCE2;
                    tmr_n = '0;
                end
                BOUNCE2: if (d[g] == val) begin
                    if (tmr > timeout) fs_n = STABLE;
                    else tmr_n = tmr_inc;
                end else begin
                    fs_n  = BOUNCE1;
                    tmr_n = '0;
                end
                default: fs_n = STABLE;
            endcase
        end
        // lock handshake: first edge latches sig_out, later edges only count until acknowledged
        always_comb begin
            ls_n  = ls;
            so_n  = so;
            cnt_n = vc ? cnt + CNT_W'(1) : cnt;
            if (ls == UNLOCKED && vc) begin
                ls_n = LOCKED;
                so_n = val_n;
            end else if (ls == LOCKED && unlock[g]) begin
                ls_n = UNLOCKED;
                so_n = val_n;
            end
        end
        assign sig_out[g]                 = so;
        assign sig_changed[g]             = (ls == LOCKED);
        assign cycles[g*CNT_W +: CNT_W]   = cnt;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed self-checking bench for debounce_multi.
module tb_debounce_multi;
    logic        clk = 0;
    logic        reset;
    logic [7:0]  sig_in, unlock, irq_en;
    logic [15:0] timeout;
    logic [7:0]  sig_out, sig_changed;
    logic [63:0] cycles;
    logic        irq;
    int          checks = 0, errors = 0;
`ifdef DEBOUNCE_MULTI_INVERT_EN
    logic [7:0]  invert = '0;
`endif
    debounce_multi dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .unlock(unlock),
`ifdef DEBOUNCE_MULTI_INVERT_EN
        .invert(invert),
`endif
        .timeout(timeout), .irq_en(irq_en), .sig_out(sig_out),
        .sig_changed(sig_changed), .cycles(cycles), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    function automatic logic [7:0] cnt(input int ch);
        return cycles[ch*8 +: 8];
    endfunction
    initial begin
        reset = 1; sig_in = '0; unlock = '0; irq_en = '0; timeout = 16'd3;
        tick(2);
        check("rst_out", {56'd0, sig_out}, 64'd0);
        check("rst_chg", {56'd0, sig_changed}, 64'd0);
        check("rst_cyc", cycles, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        reset = 0;
        // clean rising step on channel 0: completes on the 8th edge
        irq_en = 8'h01; sig_in[0] = 1;
        tick(7);
        check("c0_early", {63'd0, sig_out[0]}, 64'd0);
        tick(1);
        check("c0_out", {63'd0, sig_out[0]}, 64'd1);
        check("c0_chg", {63'd0, sig_changed[0]}, 64'd1);
        check("c0_cyc", {56'd0, cnt(0)}, 64'd1);
        check("c0_irq_lag", {63'd0, irq}, 64'd0);
        tick(1);
        check("c0_irq", {63'd0, irq}, 64'd1);
        // 4-cycle glitch on channel 1 is filtered out
        sig_in[1] = 1; tick(4); sig_in[1] = 0; tick(12);
        check("c1_out", {63'd0, sig_out[1]}, 64'd0);
        check("c1_chg", {63'd0, sig_changed[1]}, 64'd0);
        check("c1_cyc", {56'd0, cnt(1)}, 64'd0);
        // channel 2: missed edges while locked are counted, sig_out frozen
        sig_in[2] = 1; tick(8);
        check("c2_lock", {62'd0, sig_out[2], sig_changed[2]}, 64'd3);
        sig_in[2] = 0; tick(10);
        check("c2_fall_out", {63'd0, sig_out[2]}, 64'd1);
        check("c2_fall_cyc", {56'd0, cnt(2)}, 64'd2);
        sig_in[2] = 1; tick(10);
        check("c2_rise_out", {63'd0, sig_out[2]}, 64'd1);
        check("c2_rise_cyc", {56'd0, cnt(2)}, 64'd3);
        unlock[2] = 1; tick(1); unlock[2] = 0;
        check("c2_ack_out", {63'd0, sig_out[2]}, 64'd1);
        check("c2_ack_chg", {63'd0, sig_changed[2]}, 64'd0);
        // channel 3: unlock coincident with a debounced edge
        sig_in[3] = 1; tick(10);
        check("c3_lock", {62'd0, sig_out[3], sig_changed[3]}, 64'd3);
        sig_in[3] = 0; tick(7); unlock[3] = 1; tick(1); unlock[3] = 0;
        check("c3_co_out", {63'd0, sig_out[3]}, 64'd0);
        check("c3_co_chg", {63'd0, sig_changed[3]}, 64'd0);
        check("c3_co_cyc", {56'd0, cnt(3)}, 64'd2);
        sig_in[3] = 1; tick(8);
        check("c3_relock", {62'd0, sig_out[3], sig_changed[3]}, 64'd3);
        // channel 4: counter wraps after 256 edges
        timeout = 16'd0;
        for (int i = 0; i < 255; i++) begin
            sig_in[4] = ~sig_in[4]; tick(8);
        end
        check("c4_255", {56'd0, cnt(4)}, 64'd255);
        sig_in[4] = ~sig_in[4]; tick(8);
        check("c4_wrap", {56'd0, cnt(4)}, 64'd0);
        timeout = 16'd3;
        // reset mid-BOUNCE1 on channel 5 while other channels are locked
        sig_in[5] = ~sig_in[5]; tick(4);
        reset = 1; tick(1);
        check("r_out", {56'd0, sig_out}, 64'd0);
        check("r_chg", {56'd0, sig_changed}, 64'd0);
        check("r_cyc", cycles, 64'd0);
        check("r_irq", {63'd0, irq}, 64'd0);
        sig_in = '0; tick(2);
        reset = 0; sig_in[5] = 1;
        tick(7);
        check("r_c5_early", {63'd0, sig_out[5]}, 64'd0);
        tick(1);
        check("r_c5_out", {62'd0, sig_out[5], sig_changed[5]}, 64'd3);
        check("r_c5_cyc", {56'd0, cnt(5)}, 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
